multicycle_ctrl: RTL and testbench
==================================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameters: none; data width is `REG_DATA_WIDTH` (32), the instruction-set constants come from the shared package.
REQ-002 clk  in  1  sole clock, all state updates on rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 instr  in  32  current instruction from the instruction register, stable from DECODE onward.
REQ-005 br_eq, br_lt  in  1 each  branch comparator results for the current rs1/rs2.
REQ-006 imem_req out 1 / imem_ready in 1  instruction-fetch handshake.
REQ-007 dmem_req out 1 / dmem_ready in 1  data-memory handshake.
REQ-008 ir_write_en, pc_write_en  out  1 each  instruction-register and PC load strobes.
REQ-009 reg_write_en, mem_write_en, br_unsign, a_sel, b_sel  out  1 each  datapath controls.
REQ-010 alu_sel out 4; pc_sel out 2; wb_sel out 2; imm_sel out 3  datapath selects.
REQ-011 retire out 1  one-cycle pulse per completed instruction; trap out 1  illegal-instruction halt; state out 3  debug view.

Function
REQ-012 States: FETCH, DECODE, EXECUTE, MEM, WB, TRAP; all outputs are combinational from state plus instr, with no other registered outputs.
REQ-013 FETCH: imem_req=1 until imem_ready sampled 1; on that cycle ir_write_en=1 and next state is DECODE; imem_ready while imem_req=0 is ignored.
REQ-014 DECODE: one cycle; opcode not in {LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP} -> TRAP, else -> EXECUTE.
REQ-015 EXECUTE: one cycle; LOAD/STORE -> MEM; BRANCH -> FETCH; all others -> WB.
REQ-016 MEM: dmem_req=1 held stable until dmem_ready; mem_write_en=1 for STORE throughout MEM; on ready, STORE -> FETCH and LOAD -> WB.
REQ-017 WB: reg_write_en=1 for exactly one cycle, then -> FETCH.
REQ-018 pc_write_en=1 exactly once per instruction, in its final cycle (WB, MEM-ready for STORE, EXECUTE for BRANCH); retire=1 in the same cycle.
REQ-019 pc_sel: 00 = pc+4, 01 = ALU result; 01 for JAL, JALR and taken branches, otherwise 00.
REQ-020 Branch taken: BEQ eq, BNE !eq, BLT/BLTU lt, BGE/BGEU !lt; br_unsign = funct3[1] for branches, else 0.
REQ-021 wb_sel: 00 = memory (LOAD), 01 = ALU (OP, OP-IMM, LUI, AUIPC), 10 = pc+4 (JAL, JALR).
REQ-022 imm_sel: 000 I (OP-IMM, LOAD, JALR), 001 S, 010 B, 011 U, 100 J.
REQ-023 a_sel: 1 (PC) for AUIPC, JAL, BRANCH, else 0 (rs1); b_sel: 0 (rs2) for OP only, else 1 (imm).
REQ-024 alu_sel: OP = {funct7[5], funct3}; OP-IMM = {funct7[5] only when funct3=101, funct3}; LUI = 1111 (pass B); all others 0000 (add).
REQ-025 Controls other than those named for the current state read 0; mem_write_en=1 is never asserted outside MEM.
REQ-026 TRAP: trap=1, all strobes and requests 0, held until reset.
REQ-027 Cycle counts with zero-wait memories: OP/OP-IMM/LUI/AUIPC/JAL/JALR 4, LOAD 5, STORE 4, BRANCH 3; each wait cycle adds exactly 1.

Reset
REQ-028 rst=1 forces state=FETCH and trap=0 asynchronously; requests and strobes fall in the same cycle, including mid-handshake.
REQ-029 Out of reset, imem_req=1 on the first cycle after rst deasserts; no outstanding memory transaction is resumed.

Structure
REQ-030 riscv_pkg holds the state enum, opcode constants, and the pc_sel/wb_sel/imm_sel/alu_sel encodings; the datapath shares this package.
REQ-031 One sub-module, ctrl_decode, holds the pure combinational opcode/funct decoder; the FSM and handshake logic stay in multicycle_ctrl.

Verification
REQ-032 ADDI x1,x0,5 (0x00500093), zero-wait -> states F,D,E,WB; imm_sel=000, b_sel=1, alu_sel=0000, wb_sel=01; retire on cycle 4.
REQ-033 LW with dmem_ready delayed 3 cycles -> dmem_req held 4 cycles, then WB with wb_sel=00, reg_write_en=1; total 8 cycles.
REQ-034 BNE, br_eq=0 -> pc_sel=01, pc_write_en=1 in EXECUTE, reg_write_en never 1; BNE, br_eq=1 -> pc_sel=00.
REQ-035 Opcode 0x0000007F -> TRAP after DECODE; trap stays 1 for 100 cycles; rst returns state to FETCH.
REQ-036 rst asserted during MEM of SW -> dmem_req and mem_write_en drop the same cycle; imem_req=1 on the first cycle after release.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32I control encodings: FSM states, opcodes and datapath select values.
// Imported by the controller, its decoder and the datapath.
package riscv_pkg;

   localparam int REG_DATA_WIDTH = 32;

   typedef enum logic [2:0] {
      ST_FETCH   = 3'd0,
      ST_DECODE  = 3'd1,
      ST_EXECUTE = 3'd2,
      ST_MEM     = 3'd3,
      ST_WB      = 3'd4,
      ST_TRAP    = 3'd5
   } state_t;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

   localparam logic [1:0] PC_SEL_PC4 = 2'b00;
   localparam logic [1:0] PC_SEL_ALU = 2'b01;

   localparam logic [1:0] WB_SEL_MEM = 2'b00;
   localparam logic [1:0] WB_SEL_ALU = 2'b01;
   localparam logic [1:0] WB_SEL_PC4 = 2'b10;

   localparam logic [2:0] IMM_I = 3'b000;
   localparam logic [2:0] IMM_S = 3'b001;
   localparam logic [2:0] IMM_B = 3'b010;
   localparam logic [2:0] IMM_U = 3'b011;
   localparam logic [2:0] IMM_J = 3'b100;

   localparam logic [3:0] ALU_ADD    = 4'b0000;
   localparam logic [3:0] ALU_PASS_B = 4'b1111;

   function automatic logic opcode_legal(input logic [6:0] opc);
      logic ok;
      case (opc)
         OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH,
         OPC_LOAD, OPC_STORE, OPC_OP_IMM, OPC_OP: ok = 1'b1;
         default:                                 ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Pure combinational opcode/funct decoder producing datapath selects and
// instruction-class flags for the multicycle controller.
module ctrl_decode
   import riscv_pkg::*;
(
   input  logic [REG_DATA_WIDTH-1:0] instr,
   input  logic                      br_eq,
   input  logic                      br_lt,
   output logic                      legal,
   output logic                      is_load,
   output logic                      is_store,
   output logic                      is_branch,
   output logic                      br_unsign,
   output logic                      a_sel,
   output logic                      b_sel,
   output logic [3:0]                alu_sel,
   output logic [1:0]                pc_sel,
   output logic [1:0]                wb_sel,
   output logic [2:0]                imm_sel
);

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic       funct7_5;
   logic       taken;
   logic       unused_bits;

   assign opcode      = instr[6:0];
   assign funct3      = instr[14:12];
   assign funct7_5    = instr[30];
   assign unused_bits = ^{instr[31], instr[29:15], instr[11:7]};

   // Branch condition; funct3 010/011 are not branch encodings and never take
   always_comb begin
      case (funct3)
         3'b000:  taken = br_eq;
         3'b001:  taken = !br_eq;
         3'b100:  taken = br_lt;
         3'b101:  taken = !br_lt;
         3'b110:  taken = br_lt;
         3'b111:  taken = !br_lt;
         default: taken = 1'b0;
      endcase
   end

   // Opcode decode to datapath selects
   always_comb begin
      legal     = opcode_legal(opcode);
      is_load   = 1'b0;
      is_store  = 1'b0;
      is_branch = 1'b0;
      br_unsign = 1'b0;
      a_sel     = 1'b0;
      b_sel     = 1'b1;
      alu_sel   = ALU_ADD;
      pc_sel    = PC_SEL_PC4;
      wb_sel    = WB_SEL_MEM;
      imm_sel   = IMM_I;
      case (opcode)
         OPC_LUI: begin
            alu_sel = ALU_PASS_B;
            wb_sel  = WB_SEL_ALU;
            imm_sel = IMM_U;
         end
         OPC_AUIPC: begin
            a_sel   = 1'b1;
            wb_sel  = WB_SEL_ALU;
            imm_sel = IMM_U;
         end
         OPC_JAL: begin
            a_sel   = 1'b1;
            pc_sel  = PC_SEL_ALU;
            wb_sel  = WB_SEL_PC4;
            imm_sel = IMM_J;
         end
         OPC_JALR: begin
            pc_sel = PC_SEL_ALU;
            wb_sel = WB_SEL_PC4;
         end
         OPC_BRANCH: begin
            is_branch = 1'b1;
            br_unsign = funct3[1];
            a_sel     = 1'b1;
            imm_sel   = IMM_B;
            pc_sel    = taken ? PC_SEL_ALU : PC_SEL_PC4;
         end
         OPC_LOAD: begin
            is_load = 1'b1;
         end
         OPC_STORE: begin
            is_store = 1'b1;
            imm_sel  = IMM_S;
         end
         OPC_OP_IMM: begin
            wb_sel  = WB_SEL_ALU;
            // funct7[5] only selects SRAI vs SRLI; elsewhere it is immediate data
            alu_sel = {(funct3 == 3'b101) ? funct7_5 : 1'b0, funct3};
         end
         OPC_OP: begin
            b_sel   = 1'b0;
            wb_sel  = WB_SEL_ALU;
            alu_sel = {funct7_5, funct3};
         end
         default: begin
            legal = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I control FSM with fetch/data memory handshakes; all outputs are
// combinational from the state register plus the current instruction.
module multicycle_ctrl
   import riscv_pkg::*;
(
   input  logic                      clk,
   input  logic                      rst,
   input  logic [REG_DATA_WIDTH-1:0] instr,
   input  logic                      br_eq,
   input  logic                      br_lt,
   output logic                      imem_req,
   input  logic                      imem_ready,
   output logic                      dmem_req,
   input  logic                      dmem_ready,
   output logic                      ir_write_en,
   output logic                      pc_write_en,
   output logic                      reg_write_en,
   output logic                      mem_write_en,
   output logic                      br_unsign,
   output logic                      a_sel,
   output logic                      b_sel,
   output logic [3:0]                alu_sel,
   output logic [1:0]                pc_sel,
   output logic [1:0]                wb_sel,
   output logic [2:0]                imm_sel,
   output logic                      retire,
   output logic                      trap,
   output logic [2:0]                state
);

   state_t     state_r;
   state_t     next_state;
   logic       dec_legal;
   logic       dec_load;
   logic       dec_store;
   logic       dec_branch;
   logic       dec_br_unsign;
   logic       dec_a_sel;
   logic       dec_b_sel;
   logic [3:0] dec_alu_sel;
   logic [1:0] dec_pc_sel;
   logic [1:0] dec_wb_sel;
   logic [2:0] dec_imm_sel;
   logic       sel_active;

   ctrl_decode u_decode (
      .instr     (instr),
      .br_eq     (br_eq),
      .br_lt     (br_lt),
      .legal     (dec_legal),
      .is_load   (dec_load),
      .is_store  (dec_store),
      .is_branch (dec_branch),
      .br_unsign (dec_br_unsign),
      .a_sel     (dec_a_sel),
      .b_sel     (dec_b_sel),
      .alu_sel   (dec_alu_sel),
      .pc_sel    (dec_pc_sel),
      .wb_sel    (dec_wb_sel),
      .imm_sel   (dec_imm_sel)
   );

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= ST_FETCH;
      end else begin
         state_r <= next_state;
      end
   end

   // Next-state and output decode
   always_comb begin
      next_state   = state_r;
      imem_req     = 1'b0;
      dmem_req     = 1'b0;
      ir_write_en  = 1'b0;
      pc_write_en  = 1'b0;
      reg_write_en = 1'b0;
      mem_write_en = 1'b0;
      retire       = 1'b0;
      trap         = 1'b0;
      br_unsign    = 1'b0;
      a_sel        = 1'b0;
      b_sel        = 1'b0;
      alu_sel      = 4'b0000;
      pc_sel       = 2'b00;
      wb_sel       = 2'b00;
      imm_sel      = 3'b000;
      // instr is only valid from DECODE onward, so selects are gated off elsewhere
      sel_active   = (state_r == ST_DECODE) || (state_r == ST_EXECUTE) ||
                     (state_r == ST_MEM)    || (state_r == ST_WB);
      if (sel_active) begin
         br_unsign = dec_br_unsign;
         a_sel     = dec_a_sel;
         b_sel     = dec_b_sel;
         alu_sel   = dec_alu_sel;
         pc_sel    = dec_pc_sel;
         wb_sel    = dec_wb_sel;
         imm_sel   = dec_imm_sel;
      end else begin
         sel_active = 1'b0;
      end
      case (state_r)
         ST_FETCH: begin
            imem_req = 1'b1;
            if (imem_ready) begin
               ir_write_en = 1'b1;
               next_state  = ST_DECODE;
            end else begin
               next_state = ST_FETCH;
            end
         end
         ST_DECODE: begin
            next_state = dec_legal ? ST_EXECUTE : ST_TRAP;
         end
         ST_EXECUTE: begin
            if (dec_load || dec_store) begin
               next_state = ST_MEM;
            end else if (dec_branch) begin
               pc_write_en = 1'b1;
               retire      = 1'b1;
               next_state  = ST_FETCH;
            end else begin
               next_state = ST_WB;
            end
         end
         ST_MEM: begin
            dmem_req     = 1'b1;
            mem_write_en = dec_store;
            if (dmem_ready) begin
               pc_write_en = dec_store;
               retire      = dec_store;
               next_state  = dec_store ? ST_FETCH : ST_WB;
            end else begin
               next_state = ST_MEM;
            end
         end
         ST_WB: begin
            reg_write_en = 1'b1;
            pc_write_en  = 1'b1;
            retire       = 1'b1;
            next_state   = ST_FETCH;
         end
         ST_TRAP: begin
            trap       = 1'b1;
            next_state = ST_TRAP;
         end
         default: begin
            next_state = ST_FETCH;
         end
      endcase
      // Reset drops requests and strobes immediately, even mid-handshake
      if (rst) begin
         imem_req     = 1'b0;
         dmem_req     = 1'b0;
         ir_write_en  = 1'b0;
         pc_write_en  = 1'b0;
         reg_write_en = 1'b0;
         mem_write_en = 1'b0;
         retire       = 1'b0;
         trap         = 1'b0;
      end else begin
         trap = trap;
      end
   end

   assign state = state_r;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: instruction classes, handshake waits,
// trap hold and asynchronous reset during a store.
module tb_multicycle_ctrl;
   import riscv_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] instr;
   logic        br_eq, br_lt;
   logic        imem_req, imem_ready, dmem_req, dmem_ready;
   logic        ir_write_en, pc_write_en, reg_write_en, mem_write_en;
   logic        br_unsign, a_sel, b_sel;
   logic [3:0]  alu_sel;
   logic [1:0]  pc_sel, wb_sel;
   logic [2:0]  imm_sel;
   logic        retire, trap;
   logic [2:0]  state;

   int checks = 0;
   int errors = 0;
   int ncyc   = 0;

   multicycle_ctrl dut (
      .clk(clk), .rst(rst), .instr(instr), .br_eq(br_eq), .br_lt(br_lt),
      .imem_req(imem_req), .imem_ready(imem_ready),
      .dmem_req(dmem_req), .dmem_ready(dmem_ready),
      .ir_write_en(ir_write_en), .pc_write_en(pc_write_en),
      .reg_write_en(reg_write_en), .mem_write_en(mem_write_en),
      .br_unsign(br_unsign), .a_sel(a_sel), .b_sel(b_sel),
      .alu_sel(alu_sel), .pc_sel(pc_sel), .wb_sel(wb_sel), .imm_sel(imm_sel),
      .retire(retire), .trap(trap), .state(state)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
      ncyc++;
   endtask

   // Entered in FETCH: zero-wait fetch, leaves the FSM in DECODE (cycle 2)
   task automatic fetch(input logic [31:0] ins);
      ncyc = 1;
      instr = ins;
      imem_ready = 1'b1;
      #1;
      chk("fetch_state", 32'(state), 32'(ST_FETCH));
      chk("fetch_imem_req", 32'(imem_req), 32'd1);
      chk("fetch_ir_write_en", 32'(ir_write_en), 32'd1);
      cyc();
      imem_ready = 1'b0;
      #1;
      chk("decode_state", 32'(state), 32'(ST_DECODE));
   endtask

   task automatic run_simple(input logic [31:0] ins, input logic [3:0] e_alu,
                             input logic [1:0] e_wb, input logic [2:0] e_imm,
                             input logic e_a, input logic e_b, input logic [1:0] e_pc);
      fetch(ins);
      cyc();
      chk("ex_state", 32'(state), 32'(ST_EXECUTE));
      chk("ex_alu_sel", 32'(alu_sel), 32'(e_alu));
      chk("ex_imm_sel", 32'(imm_sel), 32'(e_imm));
      chk("ex_a_sel", 32'(a_sel), 32'(e_a));
      chk("ex_b_sel", 32'(b_sel), 32'(e_b));
      chk("ex_strobes", 32'({reg_write_en, pc_write_en, retire, dmem_req}), 32'd0);
      cyc();
      chk("wb_state", 32'(state), 32'(ST_WB));
      chk("wb_wb_sel", 32'(wb_sel), 32'(e_wb));
      chk("wb_pc_sel", 32'(pc_sel), 32'(e_pc));
      chk("wb_strobes", 32'({reg_write_en, pc_write_en, retire, mem_write_en}), 32'b1110);
      chk("wb_cycle", 32'(ncyc), 32'd4);
      cyc();
      chk("post_wb_state", 32'(state), 32'(ST_FETCH));
      chk("post_wb_retire", 32'(retire), 32'd0);
   endtask

   initial begin
      rst = 1'b1; instr = 32'd0; br_eq = 1'b0; br_lt = 1'b0;
      imem_ready = 1'b0; dmem_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_state", 32'(state), 32'(ST_FETCH));
      chk("rst_trap", 32'(trap), 32'd0);
      chk("rst_imem_req", 32'(imem_req), 32'd0);
      chk("rst_retire", 32'(retire), 32'd0);
      rst = 1'b0;
      #1;
      chk("post_rst_imem_req", 32'(imem_req), 32'd1);

      // ADDI x1,x0,5 and ALU/immediate class coverage
      run_simple(32'h00500093, 4'b0000, 2'b01, 3'b000, 1'b0, 1'b1, 2'b00);
      run_simple(32'h40000093, 4'b0000, 2'b01, 3'b000, 1'b0, 1'b1, 2'b00);
      run_simple(32'h402080B3, 4'b1000, 2'b01, 3'b000, 1'b0, 1'b0, 2'b00);
      run_simple(32'h4030D093, 4'b1101, 2'b01, 3'b000, 1'b0, 1'b1, 2'b00);
      run_simple(32'h123450B7, 4'b1111, 2'b01, 3'b011, 1'b0, 1'b1, 2'b00);
      run_simple(32'h00000097, 4'b0000, 2'b01, 3'b011, 1'b1, 1'b1, 2'b00);
      run_simple(32'h000000EF, 4'b0000, 2'b10, 3'b100, 1'b1, 1'b1, 2'b01);
      run_simple(32'h000100E7, 4'b0000, 2'b10, 3'b000, 1'b0, 1'b1, 2'b01);

      // Fetch wait: request held, no IR load
      imem_ready = 1'b0;
      repeat (2) begin
         cyc();
         chk("fwait_state", 32'(state), 32'(ST_FETCH));
         chk("fwait_req_ir", 32'({imem_req, ir_write_en}), 32'b10);
      end

      // LW with dmem_ready delayed 3 cycles
      fetch(32'h00012083);
      cyc();
      chk("lw_ex_state", 32'(state), 32'(ST_EXECUTE));
      cyc();
      for (int i = 0; i < 3; i++) begin
         chk("lw_mem_state", 32'(state), 32'(ST_MEM));
         chk("lw_mem_req_we_pc", 32'({dmem_req, mem_write_en, pc_write_en}), 32'b100);
         cyc();
      end
      dmem_ready = 1'b1;
      #1;
      chk("lw_mem_ready_state", 32'(state), 32'(ST_MEM));
      chk("lw_mem_ready_strobes", 32'({dmem_req, pc_write_en, retire}), 32'b100);
      cyc();
      dmem_ready = 1'b0;
      #1;
      chk("lw_wb_state", 32'(state), 32'(ST_WB));
      chk("lw_wb_sel", 32'(wb_sel), 32'(WB_SEL_MEM));
      chk("lw_wb_strobes", 32'({reg_write_en, retire, dmem_req}), 32'b110);
      chk("lw_cycles", 32'(ncyc), 32'd8);
      cyc();

      // SW zero-wait: finishes in MEM, cycle 4
      fetch(32'h0020A023);
      cyc();
      chk("sw_ex_imm_sel", 32'(imm_sel), 32'(IMM_S));
      chk("sw_ex_mem_we", 32'(mem_write_en), 32'd0);
      cyc();
      dmem_ready = 1'b1;
      #1;
      chk("sw_mem_strobes", 32'({dmem_req, mem_write_en, pc_write_en, retire, reg_write_en}), 32'b11110);
      chk("sw_cycles", 32'(ncyc), 32'd4);
      cyc();
      dmem_ready = 1'b0;
      #1;
      chk("sw_post_state", 32'(state), 32'(ST_FETCH));
      chk("sw_post_mem_we", 32'(mem_write_en), 32'd0);

      // BNE taken; imem_ready in DECODE must be ignored
      br_eq = 1'b0; br_lt = 1'b0;
      fetch(32'h00209463);
      imem_ready = 1'b1;
      #1;
      chk("bne_dec_ignore_ready", 32'({imem_req, ir_write_en}), 32'b00);
      cyc();
      imem_ready = 1'b0;
      #1;
      chk("bne_ex_state", 32'(state), 32'(ST_EXECUTE));
      chk("bne_taken_pc_sel", 32'(pc_sel), 32'(PC_SEL_ALU));
      chk("bne_ex_strobes", 32'({pc_write_en, retire, reg_write_en}), 32'b110);
      chk("bne_ex_sels", 32'({a_sel, imm_sel, br_unsign}), 32'b1_010_0);
      chk("bne_cycles", 32'(ncyc), 32'd3);
      cyc();
      chk("bne_post_state", 32'(state), 32'(ST_FETCH));
      chk("bne_post_reg_we", 32'(reg_write_en), 32'd0);

      // BNE not taken
      br_eq = 1'b1;
      fetch(32'h00209463);
      cyc();
      chk("bne_nt_pc_sel", 32'(pc_sel), 32'(PC_SEL_PC4));
      chk("bne_nt_pc_we", 32'(pc_write_en), 32'd1);
      cyc();

      // BGEU: unsigned compare, taken on !lt
      br_eq = 1'b0; br_lt = 1'b1;
      fetch(32'h0020F463);
      cyc();
      chk("bgeu_unsign", 32'(br_unsign), 32'd1);
      chk("bgeu_lt_pc_sel", 32'(pc_sel), 32'(PC_SEL_PC4));
      br_lt = 1'b0;
      #1;
      chk("bgeu_ge_pc_sel", 32'(pc_sel), 32'(PC_SEL_ALU));
      cyc();

      // Reset asserted while SW waits in MEM
      fetch(32'h0020A023);
      cyc();
      cyc();
      chk("swr_mem_req", 32'({dmem_req, mem_write_en}), 32'b11);
      cyc();
      rst = 1'b1;
      #1;
      chk("swr_rst_drop", 32'({dmem_req, mem_write_en, imem_req}), 32'b000);
      chk("swr_rst_state", 32'(state), 32'(ST_FETCH));
      cyc();
      dmem_ready = 1'b1;
      rst = 1'b0;
      #1;
      chk("swr_release", 32'({imem_req, dmem_req, mem_write_en}), 32'b100);
      dmem_ready = 1'b0;

      // Illegal opcode -> TRAP, held for 100 cycles, cleared by reset
      fetch(32'h0000007F);
      cyc();
      chk("trap_state", 32'(state), 32'(ST_TRAP));
      imem_ready = 1'b1; dmem_ready = 1'b1;
      for (int i = 0; i < 100; i++) begin
         cyc();
         chk("trap_hold", 32'({trap, imem_req, dmem_req, pc_write_en, retire}), 32'b10000);
      end
      rst = 1'b1;
      #1;
      chk("trap_rst_state", 32'(state), 32'(ST_FETCH));
      chk("trap_rst_trap", 32'(trap), 32'd0);
      cyc();
      rst = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
      #1;
      chk("trap_release_imem_req", 32'(imem_req), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
